fetch_unit: RTL

FETCH_UNIT -- requirements
Module: fetch_unit

---
 rtl/fetch_unit.sv | 114 +++++++++++
 1 files changed

// File: rtl/fetch_unit.sv
// fetch_unit: instruction fetch FSM with PC sequencing; define FETCH_TIMEOUT_EN to add a fetch watchdog with an ERR state
module fetch_unit (
    input  logic        Clock,
    input  logic        Reset,
    input  logic        pc_load,
    input  logic [1:0]  Jump,
    input  logic        Branch,
    input  logic        branch_taken,
    input  logic [25:0] jump_index,
    input  logic [15:0] branch_imm,
    input  logic [31:0] jr_addr,
    output logic        imem_req,
    output logic [31:0] imem_addr,
    input  logic        imem_ack,
    input  logic [31:0] imem_rdata,
    output logic [31:0] instr,
    output logic        instr_valid,
    output logic [31:0] pc,
    output logic [31:0] link_addr,
    output logic [31:0] retire_count,
    output logic        fetch_err
);
    localparam logic [2:0] RESET_HOLD = 3'd0;
    localparam logic [2:0] ISSUE      = 3'd1;
    localparam logic [2:0] WAIT       = 3'd2;
    localparam logic [2:0] HOLD       = 3'd3;
    localparam logic [2:0] ERR        = 3'd4;

    logic [2:0]  state;
    logic [31:0] pc4;
    logic [31:0] br_off;
    logic [31:0] next_pc;
`ifdef FETCH_TIMEOUT_EN
    logic [3:0]  wait_cnt;
    logic        timeout;
`endif

    assign pc4         = pc + 32'd4;
    assign br_off      = {{14{branch_imm[15]}}, branch_imm, 2'b00};
    assign link_addr   = pc4;
    assign imem_addr   = pc;
    assign imem_req    = !Reset && (state == ISSUE || state == WAIT);
    assign instr_valid = !Reset && state == HOLD;
`ifdef FETCH_TIMEOUT_EN
    assign timeout     = state == WAIT && !imem_ack && wait_cnt == 4'hF;
`endif

    // jumps select before branch so Branch/branch_taken never influence a jump target
    always_comb
        next_pc = (Jump == 2'b01) ? {pc4[31:28], jump_index, 2'b00} :
                  (Jump == 2'b10) ? (jr_addr & ~32'd3) :
                  (Branch && branch_taken) ? pc4 + br_off : pc4;

    // fetch sequencing, instruction capture and retire bookkeeping
    always_ff @(posedge Clock) begin
        if (Reset) begin
            state        <= RESET_HOLD;
            pc           <= 32'd0;
            instr        <= 32'd0;
            retire_count <= 32'd0;
        end else begin
            case (state)
                RESET_HOLD: state <= ISSUE;
                ISSUE: begin
                    if (imem_ack) begin
                        instr <= imem_rdata;
                        state <= HOLD;
                    end else
                        state <= WAIT;
                end
                WAIT: begin
                    if (imem_ack) begin
                        instr <= imem_rdata;
                        state <= HOLD;
                    end
`ifdef FETCH_TIMEOUT_EN
                    else if (timeout)
                        state <= ERR;
`endif
                end
                HOLD: begin
                    if (pc_load) begin
                        pc           <= next_pc;
                        retire_count <= retire_count + 32'd1;
                        state        <= ISSUE;
                    end
                end
`ifdef FETCH_TIMEOUT_EN
                ERR: state <= ERR;
`endif
                default: state <= RESET_HOLD;
            endcase
        end
    end

`ifdef FETCH_TIMEOUT_EN
    // watchdog: counts WAIT cycles since the last ISSUE, sticky error on expiry
    always_ff @(posedge Clock) begin
        if (Reset) begin
            wait_cnt  <= 4'd0;
            fetch_err <= 1'b0;
        end else begin
            if (state == ISSUE)
                wait_cnt <= 4'd0;
            else if (state == WAIT)
                wait_cnt <= wait_cnt + 4'd1;
            if (timeout)
                fetch_err <= 1'b1;
        end
    end
`else
    assign fetch_err = 1'b0;
`endif
endmodule
